// File: rtl/apb_mig_ctrl.sv
// APB slave bridging single 32-bit transfers onto the MIG native app interface:
// one masked 128-bit write or one 128-bit read (lane extracted) per APB access.
package apb_mig_pkg;
   localparam int APB_ADDR_WIDTH = 32;
   localparam int MIG_ADDR_WIDTH = 27;
   localparam int DATA_WIDTH     = 128;
   localparam int APB_DATA_WIDTH = 32;
   localparam int MASK_WIDTH     = DATA_WIDTH / 8;
   localparam logic [2:0] MIG_CMD_WR = 3'b000;
   localparam logic [2:0] MIG_CMD_RD = 3'b001;
endpackage

// One 32-bit lane of the 128-bit MIG word: write replication/mask and read pick.
module apb_mig_lane #(
   parameter int LANE  = 0,
   parameter int VEC_W = 32,
   parameter int SEL_W = 2
) (
   input  logic [SEL_W-1:0]   wr_sel,
   input  logic [SEL_W-1:0]   rd_sel,
   input  logic [VEC_W-1:0]   pwdata,
   input  logic [VEC_W/8-1:0] pstrb,
   input  logic [VEC_W-1:0]   rd_lane,
   output logic [VEC_W-1:0]   wdata,
   output logic [VEC_W/8-1:0] mask,
   output logic [VEC_W-1:0]   rd_pick
);
   assign wdata   = pwdata;
   assign mask    = (wr_sel == SEL_W'(LANE)) ? ~pstrb : '1;
   assign rd_pick = (rd_sel == SEL_W'(LANE)) ? rd_lane : '0;
endmodule

module apb_mig_ctrl
   import apb_mig_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      psel_i,
   input  logic                      penable_i,
   input  logic                      pwrite_i,
   input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
   input  logic [APB_DATA_WIDTH-1:0] pwdata_i,
   input  logic [APB_DATA_WIDTH/8-1:0] pstrb_i,
   output logic                      pready_o,
   output logic [APB_DATA_WIDTH-1:0] prdata_o,
   output logic                      pslverr_o,
   input  logic                      init_calib_complete_i,
   output logic [MIG_ADDR_WIDTH-1:0] app_addr_o,
   output logic [2:0]                app_cmd_o,
   output logic                      app_en_o,
   input  logic                      app_rdy_i,
   output logic [DATA_WIDTH-1:0]     app_wdf_data_o,
   output logic [MASK_WIDTH-1:0]     app_wdf_mask_o,
   output logic                      app_wdf_wren_o,
   output logic                      app_wdf_end_o,
   input  logic                      app_wdf_rdy_i,
   input  logic [DATA_WIDTH-1:0]     app_rd_data_i,
   input  logic                      app_rd_data_valid_i
);
   localparam int NUM_LANES = DATA_WIDTH / APB_DATA_WIDTH;
   localparam int VEC_W     = APB_DATA_WIDTH;
   localparam int STRB_W    = VEC_W / 8;
   localparam int SEL_W     = $clog2(NUM_LANES);

   typedef enum logic [2:0] {IDLE, WR, RD_CMD, RD_WAIT, RESP} state_e;
   state_e state_q, state_d;

   logic             start, addr_err;
   logic             cmd_done_q, wdf_done_q, cmd_ok, wdf_ok;
   logic [SEL_W-1:0] lane_q, wr_sel;
   logic [NUM_LANES-1:0][VEC_W-1:0]  lane_wdata, lane_rd, rd_lanes;
   logic [NUM_LANES-1:0][STRB_W-1:0] lane_mask;
   logic [VEC_W-1:0] rd_word;

   assign start    = psel_i & penable_i & init_calib_complete_i;
   assign addr_err = (paddr_i[31:28] != '0) | (paddr_i[1:0] != '0);
   assign wr_sel   = paddr_i[SEL_W+1:2];
   assign rd_lanes = app_rd_data_i;
   // A done flag or a ready seen this cycle both count as accepted.
   assign cmd_ok   = cmd_done_q | app_rdy_i;
   assign wdf_ok   = wdf_done_q | app_wdf_rdy_i;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      apb_mig_lane #(.LANE(g), .VEC_W(VEC_W), .SEL_W(SEL_W)) u_lane (
         .wr_sel  (wr_sel),
         .rd_sel  (lane_q),
         .pwdata  (pwdata_i),
         .pstrb   (pstrb_i),
         .rd_lane (rd_lanes[g]),
         .wdata   (lane_wdata[g]),
         .mask    (lane_mask[g]),
         .rd_pick (lane_rd[g])
      );
   end

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_LANES; i++) rd_word = rd_word | lane_rd[i];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = addr_err ? RESP : (pwrite_i ? WR : RD_CMD);
         WR:      if (cmd_ok && wdf_ok) state_d = RESP;
         RD_CMD:  if (app_rdy_i) state_d = RD_WAIT;
         RD_WAIT: if (app_rd_data_valid_i) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pready_o       <= 1'b0;
         pslverr_o      <= 1'b0;
         prdata_o       <= '0;
         app_en_o       <= 1'b0;
         app_wdf_wren_o <= 1'b0;
         app_wdf_end_o  <= 1'b0;
         app_cmd_o      <= MIG_CMD_WR;
         app_addr_o     <= '0;
         app_wdf_data_o <= '0;
         app_wdf_mask_o <= '1;
         cmd_done_q     <= 1'b0;
         wdf_done_q     <= 1'b0;
         lane_q         <= '0;
      end else begin
         pready_o  <= (state_d == RESP);
         pslverr_o <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               lane_q     <= wr_sel;
               cmd_done_q <= 1'b0;
               wdf_done_q <= 1'b0;
               if (addr_err) begin
                  pslverr_o <= 1'b1;
                  prdata_o  <= '0;
               end else begin
                  app_addr_o <= {paddr_i[27:4], 3'b000};
                  app_cmd_o  <= pwrite_i ? MIG_CMD_WR : MIG_CMD_RD;
                  app_en_o   <= 1'b1;
                  if (pwrite_i) begin
                     app_wdf_wren_o <= 1'b1;
                     app_wdf_end_o  <= 1'b1;
                     app_wdf_data_o <= lane_wdata;
                     app_wdf_mask_o <= lane_mask;
                  end
               end
            end
            WR: begin
               if (app_rdy_i) begin
                  app_en_o   <= 1'b0;
                  cmd_done_q <= 1'b1;
               end
               if (app_wdf_rdy_i) begin
                  app_wdf_wren_o <= 1'b0;
                  app_wdf_end_o  <= 1'b0;
                  wdf_done_q     <= 1'b1;
               end
            end
            RD_CMD:  if (app_rdy_i) app_en_o <= 1'b0;
            RD_WAIT: if (app_rd_data_valid_i) prdata_o <= rd_word;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_mig_ctrl.sv
// Directed bench for apb_mig_ctrl: vector table run back-to-back against a small
// MIG responder, plus hand sequences for reset-in-flight and post-reset recovery.
module tb_apb_mig_ctrl;
   logic         clk_i = 1'b0, rst_ni = 1'b0;
   logic         psel_i, penable_i, pwrite_i;
   logic [31:0]  paddr_i, pwdata_i, prdata_o;
   logic [3:0]   pstrb_i;
   logic         pready_o, pslverr_o, init_calib_complete_i;
   logic [26:0]  app_addr_o;
   logic [2:0]   app_cmd_o;
   logic         app_en_o, app_rdy_i, app_wdf_wren_o, app_wdf_end_o, app_wdf_rdy_i;
   logic [127:0] app_wdf_data_o, app_rd_data_i;
   logic [15:0]  app_wdf_mask_o;
   logic         app_rd_data_valid_i;

   always #5 clk_i = ~clk_i;

   apb_mig_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .psel_i(psel_i), .penable_i(penable_i),
      .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
      .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
      .init_calib_complete_i(init_calib_complete_i), .app_addr_o(app_addr_o),
      .app_cmd_o(app_cmd_o), .app_en_o(app_en_o), .app_rdy_i(app_rdy_i),
      .app_wdf_data_o(app_wdf_data_o), .app_wdf_mask_o(app_wdf_mask_o),
      .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_end_o(app_wdf_end_o),
      .app_wdf_rdy_i(app_wdf_rdy_i), .app_rd_data_i(app_rd_data_i),
      .app_rd_data_valid_i(app_rd_data_valid_i)
   );

   int     n_pass = 0, n_total = 0;
   longint cyc_cnt = 0;
   always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

   // MIG responder state, driven and observed on the falling edge
   int           rd_cnt = 0, rd_delay = 0, rdy_low = 0, wdf_low = 0;
   int           en_cnt = 0, wren_cnt = 0;
   longint       valid_cyc = 0;
   logic [127:0] mig_rdata = '0, got_data = '0, prev_data = '0;
   logic [26:0]  got_addr = '0, prev_addr = '0;
   logic [2:0]   got_cmd = '0, prev_cmd = '0;
   logic [15:0]  got_mask = '0, prev_mask = '0;
   logic         prev_en = 1'b0, prev_wren = 1'b0, unstable = 1'b0;

   initial begin
      app_rdy_i = 1'b1; app_wdf_rdy_i = 1'b1;
      app_rd_data_valid_i = 1'b0; app_rd_data_i = '0;
      forever begin
         @(negedge clk_i);
         app_rd_data_valid_i = 1'b0;
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               app_rd_data_valid_i = 1'b1;
               app_rd_data_i = mig_rdata;
               valid_cyc = cyc_cnt;
            end
         end
         app_rdy_i = !(app_en_o && rdy_low > 0);
         if (app_en_o && rdy_low > 0) rdy_low--;
         app_wdf_rdy_i = !(app_wdf_wren_o && wdf_low > 0);
         if (app_wdf_wren_o && wdf_low > 0) wdf_low--;
         if (app_en_o) en_cnt++;
         if (app_wdf_wren_o) wren_cnt++;
         if (app_en_o && app_rdy_i) begin
            got_addr = app_addr_o; got_cmd = app_cmd_o;
            if (app_cmd_o == 3'b001) rd_cnt = rd_delay;
         end
         if (app_wdf_wren_o && app_wdf_rdy_i) begin
            got_data = app_wdf_data_o; got_mask = app_wdf_mask_o;
         end
         if (app_en_o && prev_en && (app_addr_o != prev_addr || app_cmd_o != prev_cmd)) unstable = 1'b1;
         if (app_wdf_wren_o && prev_wren && (app_wdf_data_o != prev_data || app_wdf_mask_o != prev_mask)) unstable = 1'b1;
         prev_en = app_en_o; prev_addr = app_addr_o; prev_cmd = app_cmd_o;
         prev_wren = app_wdf_wren_o; prev_data = app_wdf_data_o; prev_mask = app_wdf_mask_o;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chk_i(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " pready"},  128'(pready_o), 128'(0));
      chk({tag, " pslverr"}, 128'(pslverr_o), 128'(0));
      chk({tag, " prdata"},  128'(prdata_o), 128'(0));
      chk({tag, " app_en"},  128'(app_en_o), 128'(0));
      chk({tag, " wren"},    128'(app_wdf_wren_o), 128'(0));
      chk({tag, " wdf_end"}, 128'(app_wdf_end_o), 128'(0));
      chk({tag, " cmd"},     128'(app_cmd_o), 128'(0));
      chk({tag, " addr"},    128'(app_addr_o), 128'(0));
      chk({tag, " wdata"},   app_wdf_data_o, 128'(0));
      chk({tag, " mask"},    128'(app_wdf_mask_o), 128'(16'hFFFF));
   endtask

   typedef struct {
      logic         wr;
      logic [31:0]  addr, wdata;
      logic [3:0]   strb;
      logic [127:0] rdata;
      int           rd_delay, rdy_low, wdf_low, stall;
      logic [26:0]  exp_addr;
      logic [2:0]   exp_cmd;
      logic [15:0]  exp_mask;
      logic [31:0]  exp_prdata;
      logic         exp_err;
      int           exp_lat, exp_en, exp_wren;
   } vec_t;

   vec_t vecs[9];

   // Caller sits on a falling edge; setup phase starts immediately, so successive
   // calls overlap setup with the previous response cycle (back-to-back).
   task automatic run_vec(input int idx, input vec_t v);
      int          cyc;
      logic        to, stall_bad, clr, er;
      logic [31:0] rd;
      longint      pcyc;
      string       t;
      t = $sformatf("v%0d", idx);
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = v.wr; paddr_i = v.addr;
      pwdata_i = v.wdata; pstrb_i = v.strb;
      mig_rdata = v.rdata; rd_delay = v.rd_delay; rdy_low = v.rdy_low; wdf_low = v.wdf_low;
      en_cnt = 0; wren_cnt = 0; got_addr = '0; got_cmd = '0; got_data = '0; got_mask = '0;
      if (v.stall > 0) init_calib_complete_i = 1'b0;
      @(negedge clk_i);
      clr = !pready_o;
      penable_i = 1'b1; cyc = 1; stall_bad = 1'b0; to = 1'b0;
      for (int i = 0; i < v.stall; i++) begin
         @(negedge clk_i); cyc++;
         if (pready_o || app_en_o || app_wdf_wren_o) stall_bad = 1'b1;
      end
      init_calib_complete_i = 1'b1;
      forever begin
         @(negedge clk_i); cyc++;
         if (pready_o) break;
         if (cyc > 200) begin to = 1'b1; break; end
      end
      rd = prdata_o; er = pslverr_o; pcyc = cyc_cnt;
      psel_i = 1'b0; penable_i = 1'b0;
      chk({t, " timeout"}, 128'(to), 128'(0));
      chk({t, " prev_pready_one_cycle"}, 128'(clr), 128'(1));
      chk_i({t, " latency"}, cyc, v.exp_lat);
      chk({t, " pslverr"}, 128'(er), 128'(v.exp_err));
      chk({t, " prdata"}, 128'(rd), 128'(v.exp_prdata));
      chk_i({t, " app_en_cycles"}, en_cnt, v.exp_en);
      chk_i({t, " wren_cycles"}, wren_cnt, v.exp_wren);
      if (v.exp_en > 0) begin
         chk({t, " app_addr"}, 128'(got_addr), 128'(v.exp_addr));
         chk({t, " app_cmd"}, 128'(got_cmd), 128'(v.exp_cmd));
      end
      if (v.wr && !v.exp_err) begin
         chk({t, " wdf_data"}, got_data, {4{v.wdata}});
         chk({t, " wdf_mask"}, 128'(got_mask), 128'(v.exp_mask));
      end
      if (!v.wr && !v.exp_err) chk_i({t, " pready_after_valid"}, pcyc - valid_cyc, 1);
      if (v.stall > 0) chk({t, " calib_stall_quiet"}, 128'(stall_bad), 128'(0));
   endtask

   initial begin
      logic bad;
      psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = '0;
      pwdata_i = '0; pstrb_i = '0; init_calib_complete_i = 1'b1;
      //          wr    addr          wdata         strb  rdata                                      dly rlo wlo stl exp_addr     cmd     mask      prdata        err  lat en wren
      vecs[0] = '{1'b1, 32'h0000_0128, 32'hDEAD_BEEF, 4'hF, 128'h0,                                     0, 0, 0, 0, 27'h000_0090, 3'b000, 16'hF0FF, 32'h0,         1'b0, 3, 1, 1};
      vecs[1] = '{1'b0, 32'h0000_001C, 32'h0,         4'h0, 128'h12345678_22222222_33333333_44444444, 10, 0, 0, 0, 27'h000_0008, 3'b001, 16'h0,    32'h1234_5678, 1'b0, 13, 1, 0};
      vecs[2] = '{1'b1, 32'h0000_0004, 32'h0BAD_F00D, 4'h5, 128'h0,                                     0, 3, 0, 0, 27'h000_0000, 3'b000, 16'hFFAF, 32'h1234_5678, 1'b0, 6, 4, 1};
      vecs[3] = '{1'b0, 32'h1000_0000, 32'h0,         4'h0, 128'h0,                                     0, 0, 0, 0, 27'h000_0000, 3'b000, 16'h0,    32'h0,         1'b1, 2, 0, 0};
      vecs[4] = '{1'b0, 32'h0000_0FF0, 32'h0,         4'h0, 128'h99999999_88888888_77777777_CAFEF00D,  1, 0, 0, 0, 27'h000_07F8, 3'b001, 16'h0,    32'hCAFE_F00D, 1'b0, 4, 1, 0};
      vecs[5] = '{1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 4'hF, 128'h0,                                     0, 0, 0, 0, 27'h000_0000, 3'b000, 16'h0,    32'h0,         1'b1, 2, 0, 0};
      vecs[6] = '{1'b0, 32'h0FFF_FFF8, 32'h0,         4'h0, 128'h11111111_5A5A1234_33333333_44444444,  4, 0, 0, 20, 27'h7FF_FFF8, 3'b001, 16'h0,   32'h5A5A_1234, 1'b0, 27, 1, 0};
      vecs[7] = '{1'b1, 32'h0FFF_FFFC, 32'h8765_4321, 4'h9, 128'h0,                                     0, 0, 2, 0, 27'h7FF_FFF8, 3'b000, 16'h6FFF, 32'h5A5A_1234, 1'b0, 5, 1, 3};
      vecs[8] = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'h3, 128'h0,                                     0, 0, 0, 0, 27'h000_0010, 3'b000, 16'hFFFC, 32'h0,         1'b0, 3, 1, 1};

      repeat (3) @(negedge clk_i);
      chk_reset("reset");
      rst_ni = 1'b1;
      @(negedge clk_i);
      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Reset while a read waits for data; the late data must be ignored.
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h0000_001C;
      mig_rdata = {32'hBBBB_0001, 32'hCCCC_0002, 32'hDDDD_0003, 32'hEEEE_0004};
      rd_delay = 8; rdy_low = 0; wdf_low = 0;
      @(negedge clk_i); penable_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1 chk_reset("midreset");
      psel_i = 1'b0; penable_i = 1'b0;
      @(negedge clk_i); rst_ni = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_i);
         if (pready_o || app_en_o || prdata_o != 32'h0) bad = 1'b1;
      end
      chk("stray_data_ignored", 128'(bad), 128'(0));
      run_vec(8, vecs[8]);

      @(negedge clk_i);
      chk("final pready_low", 128'(pready_o), 128'(0));
      chk("mig_signals_stable", 128'(unstable), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/apb_mig_ctrl.md
# apb_mig_ctrl

APB slave that turns single 32-bit APB transfers into single-beat commands on the Xilinx MIG native application interface. It sits directly downstream of the APB interconnect and upstream of the MIG core, and uses the `apb_mig_pkg` widths and types. Each APB write becomes one masked 128-bit MIG write. Each APB read becomes one 128-bit MIG read, from which the addressed 32-bit lane is returned.

## Interface
- APB_ADDR_WIDTH, 32, APB byte-address width (`apb_mig_pkg`)
- MIG_ADDR_WIDTH, 27, MIG app_addr width (`apb_mig_pkg`)
- DATA_WIDTH, 128, MIG data width (`apb_mig_pkg`); the mask width is DATA_WIDTH/8 = 16
- APB_DATA_WIDTH, 32, APB data width; DATA_WIDTH/APB_DATA_WIDTH = 4 lanes

Ports:
- clk_i  in  1  single clock, shared with MIG ui_clk
- rst_ni  in  1  reset, asynchronous, active-low
- psel_i, penable_i, pwrite_i  in  1 each  APB control
- paddr_i  in  32  APB byte address
- pwdata_i  in  32  APB write data
- pstrb_i  in  4  APB byte strobes
- pready_o  out  1  APB ready
- prdata_o  out  32  APB read data
- pslverr_o  out  1  APB error
- init_calib_complete_i  in  1  MIG calibration done
- app_addr_o  out  27  MIG address
- app_cmd_o  out  3  MIG command: 000 = write, 001 = read
- app_en_o  out  1  command valid
- app_rdy_i  in  1  command accepted
- app_wdf_data_o  out  128  write data
- app_wdf_mask_o  out  16  write mask (1 = byte NOT written)
- app_wdf_wren_o, app_wdf_end_o  out  1 each  write-data valid / last beat
- app_wdf_rdy_i  in  1  write FIFO ready
- app_rd_data_i  in  128  read data
- app_rd_data_valid_i  in  1  read data valid

## Operation
- FSM states: IDLE, WR, RD_CMD, RD_WAIT, RESP. Reset state is IDLE.
- **Start:** in IDLE, when psel_i & penable_i & init_calib_complete_i are all high, the block latches paddr, pwdata, pstrb and pwrite. Before calibration completes, the transfer is stalled (pready_o = 0) and no MIG activity occurs.
- **Error check:** the transfer fails if paddr_i[31:28] != 0 or paddr_i[1:0] != 0. On failure: go directly to RESP with pslverr = 1, prdata = 0, and issue no MIG command.
- **Address mapping:** app_addr = {paddr[27:4], 3'b000}. The lane select is k = paddr[3:2].
- **Write path:** app_wdf_data = pwdata replicated into all 4 lanes. app_wdf_mask = all ones, except bits [4k+3:4k] = ~pstrb.
- **WR state:**
  - app_en and app_wdf_wren/app_wdf_end are asserted together.
  - Each is dropped independently on the cycle its ready (app_rdy / app_wdf_rdy) is seen high, tracked by two done flags.
  - Go to RESP when both have been accepted.
- **Read path:**
  - RD_CMD asserts app_en with cmd 001 until app_rdy is high, then goes to RD_WAIT.
  - RD_WAIT waits for app_rd_data_valid, captures lane k of app_rd_data into prdata, then goes to RESP.
- **RESP state:** pready_o = 1 for exactly one cycle, pslverr_o valid in that cycle, then return to IDLE.
- **Output hold:** prdata_o holds its value until the next read or error response. Write responses leave prdata_o unchanged.
- **Stray read data:** app_rd_data_valid in any state other than RD_WAIT is ignored.
- **Registered outputs:** all outputs are registered. app_addr, app_cmd, wdf data and mask are stable whenever app_en or app_wdf_wren is high.

## Timing
- **Reset values:** pready 0, pslverr 0, prdata 0, app_en 0, app_wdf_wren 0, app_wdf_end 0, app_cmd 000, app_addr 0, app_wdf_data 0, app_wdf_mask all ones.
- **Reset mid-transaction:** all outputs return to reset values asynchronously. The outstanding MIG command is abandoned. Read data arriving after reset is ignored.
- **Write latency:** with the ready signals high, access-phase cycle 1 is IDLE → WR, cycle 2 is WR (both accepted), cycle 3 has pready = 1.
- **Read latency:** with app_rdy high, pready rises 1 cycle after the app_rd_data_valid cycle.
- **Error latency:** pready = 1 in the 2nd access cycle.
- **Ready-low behaviour:** app_rdy or app_wdf_rdy low extends WR/RD_CMD indefinitely, with signals held stable.
- **Back-to-back:** a new transfer can start in the IDLE cycle immediately after RESP.

## Test plan
- **Write lane 2:** write paddr=0x0000_0128, pwdata=0xDEAD_BEEF, pstrb=0xF → app_addr=0x000_0090, cmd 000, wdf_data lanes all 0xDEADBEEF, mask=0xF0FF, pready in 3rd access cycle, pslverr=0.
- **Read lane 3:** read paddr=0x0000_001C, MIG returns data with lane 3 = 0x1234_5678 after 10 cycles → cmd 001, app_addr=0x008, prdata=0x12345678 one cycle after valid.
- **Split handshake:** write with app_rdy low for 3 cycles while app_wdf_rdy is high → wren drops after 1 cycle, app_en held 4 cycles, single pready afterwards.
- **Errors:**
  - paddr=0x1000_0000 → pslverr=1, prdata=0, no app_en ever.
  - paddr=0x0000_0002 → same response.
- **Calibration stall:** init_calib_complete low for 20 cycles during an access phase → pready and app_en stay 0, then the normal read completes.
- **Reset during RD_WAIT:** rst_ni low during RD_WAIT, then app_rd_data_valid pulses after release → outputs reset immediately, no pready, the stray data is ignored, and a subsequent write works.
